mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ALUoutput_EX_MEM  in  XLEN  effective byte address.
REQ-005 MemRD_out / MemWR_out  in  1 each  load / store request from the EX/MEM register.
REQ-006 MemRWType_out  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 rd2_out  in  XLEN  store data.
REQ-008 dmem_req  out  1  bus request.
REQ-009 dmem_we  out  1  bus write.
REQ-010 dmem_addr  out  XLEN  word address {addr[31:2],2'b00}.
REQ-011 dmem_be  out  4  byte enables.
REQ-012 dmem_wdata  out  XLEN  aligned store data.
REQ-013 dmem_gnt  in  1  request accepted.
REQ-014 dmem_rvalid  in  1  read data valid.
REQ-015 dmem_rdata  in  XLEN  raw read word.
REQ-016 load_data  out  XLEN  extended load result, held until the next load completes.
REQ-017 mem_pause  out  1  stall request to the upstream pipeline registers.
REQ-018 mem_fault  out  1  one-cycle misaligned/illegal access pulse.

Function
REQ-019 States: IDLE, REQ, WAIT, DONE.
REQ-020 IDLE: a valid, aligned access goes to REQ next cycle; mem_pause is high combinationally in that same cycle.
REQ-021 REQ: dmem_req held high with stable addr/be/wdata/we until dmem_gnt. On gnt, a store goes to DONE and a load goes to WAIT.
REQ-022 WAIT: on dmem_rvalid, capture the extended data into load_data and go to DONE. dmem_rvalid outside WAIT is ignored.
REQ-023 DONE: mem_pause low for exactly one cycle, then return to IDLE without reissuing the access.
REQ-024 mem_pause is high in IDLE-with-access, REQ and WAIT; low otherwise.
REQ-025 Minimum load latency: 4 cycles from access presented to DONE, with gnt and rvalid each arriving in the first cycle possible. Minimum store latency: 3 cycles.
REQ-026 Alignment rules: H/HU/SH need addr[0]=0; W/SW need addr[1:0]=0.
REQ-027 A misaligned access, an illegal MemRWType (011, 110, 111, or a U-type on a store), or MemRD&MemWR together: mem_fault high for 1 cycle, no bus request, mem_pause low, load_data unchanged.
REQ-028 Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-029 Store data: wdata carries the store byte/half replicated across all lanes.
REQ-030 Load extraction: raw word >> (addr[1:0]*8), then sign-extend (B, H) or zero-extend (BU, HU) to XLEN.
REQ-031 A dmem_gnt arriving in the same cycle as dmem_req first rises is valid.
REQ-032 dmem_req is never asserted outside REQ.

Reset
REQ-033 rst high at any clock edge, including mid-transaction: state IDLE, dmem_req 0, dmem_we 0, dmem_be 0, dmem_addr 0, dmem_wdata 0, load_data 0, mem_fault 0.
REQ-034 mem_pause is 0 during reset.
REQ-035 A response arriving after reset is ignored.

Structure
REQ-036 Package mem_pkg holds the MemRWType encodings and the state encoding.
REQ-037 Sub-module load_align is combinational: raw word, addr[1:0] and type in; extended data out.

Verification
REQ-038 LW addr 0x100, rdata 0x8899AABB, gnt and rvalid immediate: load_data=0x8899AABB, mem_pause high for 3 cycles, DONE in cycle 4.
REQ-039 LB addr 0x103, rdata 0x80FF0000: load_data=0xFFFFFF80. LBU at the same address: 0x00000080.
REQ-040 SH addr 0x102, rd2 0x1234ABCD: be=4'b1100, wdata=0xABCDABCD, we=1, dmem_addr=0x100.
REQ-041 LW addr 0x101: mem_fault pulses once, dmem_req never asserts, mem_pause stays low.
REQ-042 gnt delayed 5 cycles: req and addr stable throughout, mem_pause high throughout.
REQ-043 rst asserted in WAIT, then rvalid arrives: state IDLE, load_data=0, the response is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and access legality for the data memory access unit
package mem_pkg;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_DONE = 2'b11
   } mau_state_e;

   // Exactly one of load/store, a defined width, and natural alignment; U-types are load-only.
   function automatic logic access_ok(input logic       is_load,
                                      input logic       is_store,
                                      input logic [2:0] rwtype,
                                      input logic [1:0] off);
      logic ok;
      case (rwtype)
         MEM_B:   ok = 1'b1;
         MEM_H:   ok = ~off[0];
         MEM_W:   ok = (off == 2'b00);
         MEM_BU:  ok = is_load;
         MEM_HU:  ok = is_load & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok & (is_load ^ is_store);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/grant/response data memory bus
interface mem_access_unit_if #(
   parameter int XLEN = 32
);

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - combinational lane select and sign/zero extension of a load word
module load_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] raw_i,
   input  logic [1:0]      off_i,
   input  logic [2:0]      type_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] shifted;

   assign shifted = raw_i >> {off_i, 3'b000};

   always_comb begin
      data_o = shifted;
      case (type_i)
         MEM_B:   data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         MEM_H:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         MEM_BU:  data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         MEM_HU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer with pipeline stall and fault reporting
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   ALUoutput_EX_MEM,
   input  logic              MemRD_out,
   input  logic              MemWR_out,
   input  logic [2:0]        MemRWType_out,
   input  logic [XLEN-1:0]   rd2_out,
   mem_access_unit_if.master dmem,
   output logic [XLEN-1:0]   load_data,
   output logic              mem_pause,
   output logic              mem_fault
);

   mau_state_e      state_q, state_d;
   logic            access, legal;
   logic            capture, load_en, pause_c, fault_c;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            we_q;
   logic [1:0]      off_q;
   logic [2:0]      type_q;
   logic [XLEN-1:0] load_data_q, load_ext;

   assign access = MemRD_out | MemWR_out;
   assign legal  = access_ok(MemRD_out, MemWR_out, MemRWType_out, ALUoutput_EX_MEM[1:0]);
   assign addr_d = {ALUoutput_EX_MEM[XLEN-1:2], 2'b00};

   // Lane enables and lane-replicated store data, latched once so the bus stays stable until grant.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = rd2_out;
      case (MemRWType_out[1:0])
         2'b00: begin
            be_d    = 4'b0001 << ALUoutput_EX_MEM[1:0];
            wdata_d = {(XLEN/8){rd2_out[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << ALUoutput_EX_MEM[1:0];
            wdata_d = {(XLEN/16){rd2_out[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = rd2_out;
         end
      endcase
   end

   load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .raw_i  (dmem.dmem_rdata),
      .off_i  (off_q),
      .type_i (type_q),
      .data_o (load_ext)
   );

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      load_en = 1'b0;
      pause_c = 1'b0;
      fault_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (legal) begin
               pause_c = 1'b1;
               capture = 1'b1;
               state_d = S_REQ;
            end else if (access) begin
               fault_c = 1'b1;
            end
         end
         S_REQ: begin
            pause_c = 1'b1;
            if (dmem.dmem_gnt) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            pause_c = 1'b1;
            if (dmem.dmem_rvalid) begin
               load_en = 1'b1;
               state_d = S_DONE;
            end
         end
         // The upstream register advances during this cycle, so the held access is not re-taken.
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         off_q       <= '0;
         type_q      <= '0;
         load_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= MemWR_out;
            off_q   <= ALUoutput_EX_MEM[1:0];
            type_q  <= MemRWType_out;
         end
         if (load_en) begin
            load_data_q <= load_ext;
         end
      end
   end

   assign dmem.dmem_req   = (state_q == S_REQ);
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_be    = be_q;
   assign dmem.dmem_wdata = wdata_q;

   assign load_data = load_data_q;
   assign mem_pause = pause_c & ~rst;
   assign mem_fault = fault_c & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic [31:0] alu;
   logic        memrd, memwr;
   logic [2:0]  rwtype;
   logic [31:0] rd2;
   logic [31:0] load_data;
   logic        mem_pause, mem_fault;

   mem_access_unit_if #(.XLEN(32)) bus ();

   mem_access_unit #(.XLEN(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .ALUoutput_EX_MEM (alu),
      .MemRD_out        (memrd),
      .MemWR_out        (memwr),
      .MemRWType_out    (rwtype),
      .rd2_out          (rd2),
      .dmem             (bus),
      .load_data        (load_data),
      .mem_pause        (mem_pause),
      .mem_fault        (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        chk_en = 1'b0;
   logic        exp_req, exp_pause, exp_fault, exp_we;
   logic [31:0] exp_load, exp_addr, exp_wdata;
   logic [3:0]  exp_be;

   int          pause_cnt, req_cnt, fault_cnt;
   logic [3:0]  cap_be;
   logic [31:0] cap_wdata, cap_addr;
   logic        cap_we;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference rules
   function automatic logic ref_legal(input logic rd, input logic wr, input logic [2:0] t, input logic [31:0] a);
      int size;
      if (rd == wr) return 1'b0;
      if (t == 3'd3 || t > 3'd5) return 1'b0;
      if (t[2] && wr) return 1'b0;
      size = 1 << t[1:0];
      return (a % size) == 0;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [31:0] a);
      int size;
      size = 1 << t[1:0];
      return 4'(((1 << size) - 1) << a[1:0]);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] t, input logic [31:0] d);
      if (t[1:0] == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
      if (t[1:0] == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [2:0] t, input logic [31:0] a);
      int          bits;
      logic [31:0] sh, mask, v;
      bits = 8 * (1 << t[1:0]);
      sh   = raw >> (8 * a[1:0]);
      if (bits >= 32) return sh;
      mask = (32'd1 << bits) - 1;
      v    = sh & mask;
      if (!t[2] && sh[bits-1]) v = v | ~mask;
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req", bus.dmem_req, exp_req);
         chk("pause", mem_pause, exp_pause);
         chk("fault", mem_fault, exp_fault);
         chk("load_data", load_data, exp_load);
         if (exp_req) begin
            chk("addr", bus.dmem_addr, exp_addr);
            chk("we", bus.dmem_we, exp_we);
            if (exp_we) begin
               chk("be", bus.dmem_be, exp_be);
               chk("wdata", bus.dmem_wdata, exp_wdata);
            end
         end
         if (mem_pause) pause_cnt++;
         if (mem_fault) fault_cnt++;
         if (bus.dmem_req) begin
            req_cnt++;
            cap_be    = bus.dmem_be;
            cap_wdata = bus.dmem_wdata;
            cap_addr  = bus.dmem_addr;
            cap_we    = bus.dmem_we;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      memrd           = 1'b0;
      memwr           = 1'b0;
      alu             = $urandom;
      rwtype          = 3'($urandom);
      rd2             = $urandom;
      bus.dmem_gnt    = 1'($urandom);
      bus.dmem_rvalid = 1'($urandom);
      bus.dmem_rdata  = $urandom;
      exp_req   = 1'b0;
      exp_pause = 1'b0;
      exp_fault = 1'b0;
      step();
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b0;
   endtask

   task automatic do_access(input logic rd, input logic wr, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int gd, input int rdly, input logic [31:0] raw);
      logic ok;
      ok = ref_legal(rd, wr, t, a);
      memrd  = rd;
      memwr  = wr;
      rwtype = t;
      alu    = a;
      rd2    = wd;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b0;
      exp_req   = 1'b0;
      exp_fault = (rd | wr) & ~ok;
      exp_pause = ok;
      step();
      if (!ok) return;
      exp_fault = 1'b0;
      exp_req   = 1'b1;
      exp_addr  = a & ~32'd3;
      exp_we    = wr;
      exp_be    = ref_be(t, a);
      exp_wdata = ref_wdata(t, wd);
      for (int i = 0; i <= gd; i++) begin
         bus.dmem_gnt   = (i == gd);
         bus.dmem_rdata = $urandom;
         step();
      end
      bus.dmem_gnt = 1'b0;
      exp_req      = 1'b0;
      if (rd) begin
         for (int i = 0; i <= rdly; i++) begin
            bus.dmem_rvalid = (i == rdly);
            bus.dmem_rdata  = (i == rdly) ? raw : $urandom;
            step();
         end
         bus.dmem_rvalid = 1'b0;
         exp_load = ref_load(raw, t, a);
      end
      exp_pause = 1'b0;
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] t;
      logic       rd, wr;
      int         k;
      rst = 1'b1;
      memrd = 1'b0; memwr = 1'b0; rwtype = 3'd0; alu = 32'd0; rd2 = 32'd0;
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
      exp_req = 1'b0; exp_pause = 1'b0; exp_fault = 1'b0; exp_load = 32'd0;
      exp_we = 1'b0; exp_addr = 32'd0; exp_be = 4'd0; exp_wdata = 32'd0;
      pause_cnt = 0; req_cnt = 0; fault_cnt = 0;
      step();
      chk_en = 1'b1;
      chk("rst_addr", bus.dmem_addr, 32'd0);
      chk("rst_be", {28'd0, bus.dmem_be}, 32'd0);
      chk("rst_wdata", bus.dmem_wdata, 32'd0);
      chk("rst_we", {31'd0, bus.dmem_we}, 32'd0);
      chk("rst_load", load_data, 32'd0);
      rst = 1'b0;
      idle_cycle();
      idle_cycle();

      pause_cnt = 0;
      do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 32'h8899AABB);
      chk("lw_data", load_data, 32'h8899AABB);
      chk("lw_pause_cycles", pause_cnt, 32'd3);

      do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h80FF0000);
      chk("lb_data", load_data, 32'hFFFFFF80);
      do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 0, 32'h80FF0000);
      chk("lbu_data", load_data, 32'h00000080);

      do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'd0);
      chk("sh_be", {28'd0, cap_be}, 32'h0000000C);
      chk("sh_wdata", cap_wdata, 32'hABCDABCD);
      chk("sh_we", {31'd0, cap_we}, 32'd1);
      chk("sh_addr", cap_addr, 32'h100);

      pause_cnt = 0; req_cnt = 0; fault_cnt = 0;
      do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 0, 32'hFFFFFFFF);
      idle_cycle();
      chk("mis_fault_pulses", fault_cnt, 32'd1);
      chk("mis_req_cycles", req_cnt, 32'd0);
      chk("mis_pause_cycles", pause_cnt, 32'd0);
      chk("mis_load_kept", load_data, 32'h00000080);

      pause_cnt = 0; req_cnt = 0;
      do_access(1'b0, 1'b1, 3'b010, 32'h140, 32'hCAFEF00D, 5, 0, 32'd0);
      chk("gnt5_pause_cycles", pause_cnt, 32'd7);
      chk("gnt5_req_cycles", req_cnt, 32'd6);
      chk("gnt5_wdata", cap_wdata, 32'hCAFEF00D);

      // reset while waiting for read data, then a late response
      memrd = 1'b1; memwr = 1'b0; rwtype = 3'b010; alu = 32'h200;
      exp_pause = 1'b1; exp_req = 1'b0; exp_fault = 1'b0;
      step();
      bus.dmem_gnt = 1'b1; exp_req = 1'b1; exp_addr = 32'h200; exp_we = 1'b0;
      step();
      bus.dmem_gnt = 1'b0; exp_req = 1'b0; exp_pause = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; memrd = 1'b0; exp_load = 32'd0;
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
      chk("rstwait_addr", bus.dmem_addr, 32'd0);
      chk("rstwait_load", load_data, 32'd0);
      step();
      bus.dmem_rvalid = 1'b0;
      chk("late_resp_ignored", load_data, 32'd0);
      chk("late_resp_no_req", {31'd0, bus.dmem_req}, 32'd0);
      idle_cycle();

      for (int n = 0; n < 120; n++) begin
         k = $urandom_range(0, 9);
         t = 3'($urandom);
         if (k == 0) begin
            idle_cycle();
         end else begin
            rd = (k <= 4) || (k == 9);
            wr = (k >= 5);
            do_access(rd, wr, t, $urandom & 32'h0000_0FFF, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         end
      end
      idle_cycle();
      idle_cycle();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
